// File: rtl/seq_subtractor32.sv
// seq_subtractor32: two-slice multi-cycle subtractor D = A - B - bin with NZVB flags
module seq_subtractor32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             busy,
    output logic             done
);
    localparam int H = WIDTH / 2;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, d_q, d_d;
    logic bin_q, c_mid_q, bout_q, n_q, z_q, v_q, busy_q, done_q, accept;
    logic [H:0] lo_sum, hi_sum;
    assign lo_sum = {1'b0, a_q[H-1:0]} + {1'b0, ~b_q[H-1:0]} + {{H{1'b0}}, ~bin_q};
    assign hi_sum = {1'b0, a_q[WIDTH-1:H]} + {1'b0, ~b_q[WIDTH-1:H]} + {{H{1'b0}}, c_mid_q};
    assign d_d = {hi_sum[H-1:0], d_q[H-1:0]};
    assign {D, bout, N, Z, V, busy, done} = {d_q, bout_q, n_q, z_q, v_q, busy_q, done_q};
    // next state: a request is taken from IDLE or DONE, otherwise walk LO -> HI -> DONE -> IDLE
    always_comb begin
        accept  = start && (state_q == IDLE || state_q == DONE);
        state_d = accept ? LO : state_q == LO ? HI : state_q == HI ? DONE : IDLE;
    end
    // state, operand capture, per-slice result update and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bin_q   <= 1'b0;
            c_mid_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d == LO || state_d == HI;
            done_q  <= state_d == DONE;
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                bin_q <= bin;
            end
            if (state_q == LO) begin
                d_q[H-1:0] <= lo_sum[H-1:0];
                c_mid_q    <= lo_sum[H];
            end
            if (state_q == HI) begin
                d_q    <= d_d;
                bout_q <= ~hi_sum[H];
                n_q    <= d_d[WIDTH-1];
                z_q    <= d_d == '0;
                v_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_d[WIDTH-1] != a_q[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_seq_subtractor32.sv
// tb_seq_subtractor32: randomized and directed checks against an arithmetic reference model
module tb_seq_subtractor32;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        bin = 1'b0;
    logic [31:0] D;
    logic        bout, N, Z, V, busy, done;
    int n_chk = 0;
    int n_pass = 0;
    seq_subtractor32 dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .bin(bin),
        .D(D), .bout(bout), .N(N), .Z(Z), .V(V), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bi);
        longint diff;
        logic [63:0] dv;
        logic [31:0] ed;
        diff = longint'({32'b0, a}) - longint'({32'b0, b}) - longint'(bi);
        dv = diff;
        ed = dv[31:0];
        check({tag, ".D"}, D, ed);
        check({tag, ".bout"}, {31'b0, bout}, {31'b0, diff < 0});
        check({tag, ".N"}, {31'b0, N}, {31'b0, ed[31]});
        check({tag, ".Z"}, {31'b0, Z}, {31'b0, ed == 0});
        check({tag, ".V"}, {31'b0, V}, {31'b0, (a[31] != b[31]) && (ed[31] != a[31])});
    endtask
    task automatic scramble();
        A = $urandom;
        B = $urandom;
        bin = 1'($urandom_range(1));
    endtask
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bi, input bit hold);
        A = a;
        B = b;
        bin = bi;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        scramble();
        check({tag, ".busy1"}, {30'b0, busy, done}, 32'd2);
        tick();
        scramble();
        check({tag, ".busy2"}, {30'b0, busy, done}, 32'd2);
        tick();
        check({tag, ".done"}, {30'b0, busy, done}, 32'd1);
        check_result(tag, a, b, bi);
    endtask
    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst.D", D, 32'd0);
        check("rst.flags", {26'b0, bout, N, Z, V, busy, done}, 32'd0);
        tick();
        tick();
        check("idle.flags", {26'b0, bout, N, Z, V, busy, done}, 32'd0);
        run_op("t2", 32'd5, 32'd3, 1'b0, 0);
        tick();
        check("t2.after", {30'b0, busy, done}, 32'd0);
        check("t2.hold", D, 32'd2);
        run_op("t3", 32'd0, 32'd1, 1'b0, 0);
        run_op("t4", 32'h0001_0000, 32'h0000_0001, 1'b1, 0);
        check("t4.lit", D, 32'h0000_FFFE);
        run_op("t5a", 32'h8000_0000, 32'd1, 1'b0, 0);
        check("t5a.V", {31'b0, V}, 32'd1);
        run_op("t5b", 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        check("t5b.Z", {31'b0, Z}, 32'd1);
        run_op("edge", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("edge2", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            run_op("rnd", $urandom, $urandom, 1'($urandom_range(1)), 0);
            if ($urandom_range(1) == 1) tick();
        end
        for (int i = 0; i < 6; i++) run_op("b2b", $urandom, $urandom, 1'($urandom_range(1)), 1);
        start = 1'b0;
        tick();
        check("b2b.end", {30'b0, busy, done}, 32'd0);
        run_op("pre", 32'd100, 32'd7, 1'b0, 0);
        A = 32'd9;
        B = 32'd20;
        bin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid.D", D, 32'd0);
        check("mid.flags", {26'b0, bout, N, Z, V, busy, done}, 32'd0);
        tick();
        check("mid.nodone", {30'b0, busy, done}, 32'd0);
        tick();
        check("mid.idle", {26'b0, bout, N, Z, V, busy, done}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
